btb_assoc_mt: RTL and testbench

Parametrised, set-associative, multi-thread branch target buffer. It replaces the single-thread, direct-mapped, combinational-hit BTB lookup in the fetch front end. The block adds:
- a registered lookup pipeline;
- an update/allocate port with per-set round-robin replacement;
- a hardware invalidate sequencer for reset and per-thread flush.

---
 rtl/btb_assoc_mt.sv | 267 ++++++++++++++++++++++++++
 tb/tb_btb_assoc_mt.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_mt.sv
`default_nettype none
// ============================================================================
// Module   : btb_assoc_mt
// Purpose  : Set-associative, multi-thread branch target buffer with a
//            registered lookup pipeline, an update/allocate port with per-set
//            round-robin replacement, and a hardware invalidate sequencer
//            used after reset (all entries) and for per-thread flushes.
// Ports    : clk, rst (synchronous, active-high)
//            predict_valid/pc/thread  -> predict_ready
//            resp_valid/hit/target/type (one cycle after accept)
//            update_valid/pc/thread/target/type -> update_ready
//            flush_valid/flush_thread -> flush_busy
//            stat_hits/stat_misses/stat_evicts (only with BTB_STATS_EN)
// Options  : `define BTB_STATS_EN to add saturating hit/miss/evict counters.
// Revision : 1.0 - initial release
// ============================================================================
module btb_assoc_mt #(
  parameter int SETS    = 1024,
  parameter int WAYS    = 2,
  parameter int THREADS = 2,
  parameter int PC_W    = 64,
  parameter int OFF_W   = 2,
  parameter int TGT_W   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       predict_valid,
  input  logic [PC_W-1:0]            predict_pc,
  input  logic [$clog2(THREADS)-1:0] predict_thread,
  output logic                       predict_ready,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [TGT_W-1:0]           resp_target,
  output logic [1:0]                 resp_type,
  input  logic                       update_valid,
  input  logic [PC_W-1:0]            update_pc,
  input  logic [$clog2(THREADS)-1:0] update_thread,
  input  logic [TGT_W-1:0]           update_target,
  input  logic [1:0]                 update_type,
  output logic                       update_ready,
  input  logic                       flush_valid,
  input  logic [$clog2(THREADS)-1:0] flush_thread,
  output logic                       flush_busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_misses,
  output logic [31:0]                stat_evicts
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - OFF_W;
  localparam int TID_W = $clog2(THREADS);
  // A 1-way cache still needs a 1-bit way/pointer signal to stay legal.
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sweep;
  logic [TID_W-1:0] r_flush_tid;

  // Entry storage: valid bits and RR pointers are flops (swept by the
  // invalidate sequencer); the payload fields carry no reset.
  logic             r_valid [SETS][WAYS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [TGT_W-1:0] r_tgt   [SETS][WAYS];
  logic [1:0]       r_type  [SETS][WAYS];
  logic [TID_W-1:0] r_tid   [SETS][WAYS];
  logic [WAY_W-1:0] r_rr    [SETS];

  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [TGT_W-1:0] r_resp_tgt;
  logic [1:0]       r_resp_type;

  // Dropped low PC bits are intentionally not used.
  logic w_unused_ok;
  assign w_unused_ok = ^{predict_pc[OFF_W-1:0], update_pc[OFF_W-1:0]};

  logic w_ready;
  logic w_p_acc;
  logic w_u_acc;
  assign w_ready = (r_state == ST_READY);
  assign w_p_acc = predict_valid && w_ready;
  assign w_u_acc = update_valid && w_ready;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] w_p_idx;
  logic [TAG_W-1:0] w_p_tag;
  logic             w_p_hit;
  logic [TGT_W-1:0] w_p_tgt;
  logic [1:0]       w_p_type;
  assign w_p_idx = predict_pc[IDX_W+OFF_W-1:OFF_W];
  assign w_p_tag = predict_pc[PC_W-1:IDX_W+OFF_W];

  // Lowest-numbered hitting way wins.
  always_comb begin
    w_p_hit  = 1'b0;
    w_p_tgt  = '0;
    w_p_type = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_p_hit && r_valid[w_p_idx][w] && (r_tag[w_p_idx][w] == w_p_tag) &&
          (r_tid[w_p_idx][w] == predict_thread)) begin
        w_p_hit  = 1'b1;
        w_p_tgt  = r_tgt[w_p_idx][w];
        w_p_type = r_type[w_p_idx][w];
      end
    end
  end

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [WAY_W-1:0] w_u_hit_way;
  logic             w_u_inv;
  logic [WAY_W-1:0] w_u_inv_way;
  logic [WAY_W-1:0] w_u_way;
  logic             w_u_evict;
  logic [WAY_W-1:0] w_rr_nxt;
  assign w_u_idx = update_pc[IDX_W+OFF_W-1:OFF_W];
  assign w_u_tag = update_pc[PC_W-1:IDX_W+OFF_W];

  always_comb begin
    w_u_hit     = 1'b0;
    w_u_hit_way = '0;
    w_u_inv     = 1'b0;
    w_u_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_u_hit && r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag) &&
          (r_tid[w_u_idx][w] == update_thread)) begin
        w_u_hit     = 1'b1;
        w_u_hit_way = WAY_W'(w);
      end
      if (!w_u_inv && !r_valid[w_u_idx][w]) begin
        w_u_inv     = 1'b1;
        w_u_inv_way = WAY_W'(w);
      end
    end
  end

  // A miss into a full set is the only case that displaces a valid entry
  // and the only case that advances the round-robin pointer.
  assign w_u_evict = !w_u_hit && !w_u_inv;
  assign w_u_way   = w_u_hit ? w_u_hit_way : (w_u_inv ? w_u_inv_way : r_rr[w_u_idx]);
  assign w_rr_nxt  = (r_rr[w_u_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_u_idx] + WAY_W'(1);

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_flush_tid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_READY) begin
        r_sweep <= '0;
        if (flush_valid) r_flush_tid <= flush_thread;
      end else begin
        r_sweep <= r_sweep + IDX_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_sweep == IDX_W'(SETS - 1)) w_state_nxt = ST_READY;
      ST_READY: if (flush_valid) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_sweep == IDX_W'(SETS - 1)) w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // ------------------------------------------- valid bits and RR pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (r_state)
        ST_INIT: begin
          r_rr[r_sweep] <= '0;
          for (int w = 0; w < WAYS; w++) r_valid[r_sweep][w] <= 1'b0;
        end
        ST_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            if (r_tid[r_sweep][w] == r_flush_tid) r_valid[r_sweep][w] <= 1'b0;
          end
        end
        ST_READY: begin
          if (w_u_acc) begin
            r_valid[w_u_idx][w_u_way] <= 1'b1;
            if (w_u_evict) r_rr[w_u_idx] <= w_rr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ payload storage
  always_ff @(posedge clk) begin
    if (!rst && w_u_acc) begin
      r_tgt[w_u_idx][w_u_way]  <= update_target;
      r_type[w_u_idx][w_u_way] <= update_type;
      if (!w_u_hit) begin
        r_tag[w_u_idx][w_u_way] <= w_u_tag;
        r_tid[w_u_idx][w_u_way] <= update_thread;
      end
    end
  end

  // ------------------------------------------------------ response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_tgt   <= '0;
      r_resp_type  <= '0;
    end else begin
      r_resp_valid <= w_p_acc;
      r_resp_hit   <= w_p_acc && w_p_hit;
      r_resp_tgt   <= w_p_acc ? w_p_tgt : '0;
      r_resp_type  <= w_p_acc ? w_p_type : '0;
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign resp_target   = r_resp_tgt;
  assign resp_type     = r_resp_type;
  assign predict_ready = w_ready;
  assign update_ready  = w_ready;
  assign flush_busy    = !w_ready;

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;
  logic [31:0] r_stat_evicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_evicts <= '0;
    end else begin
      if (r_resp_valid && r_resp_hit && (r_stat_hits != '1))
        r_stat_hits <= r_stat_hits + 32'd1;
      if (r_resp_valid && !r_resp_hit && (r_stat_misses != '1))
        r_stat_misses <= r_stat_misses + 32'd1;
      if (w_u_acc && w_u_evict && (r_stat_evicts != '1))
        r_stat_evicts <= r_stat_evicts + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_evicts = r_stat_evicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc_mt.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_assoc_mt
// Purpose  : Self-checking bench for btb_assoc_mt (SETS=16, WAYS=2).
//            Lookups push their expected response onto a scoreboard queue;
//            a negedge monitor pops and compares each response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_assoc_mt;

  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int THREADS = 2;
  localparam int PC_W = 64;
  localparam int OFF_W = 2;
  localparam int TGT_W = 64;

  logic             clk;
  logic             rst;
  logic             predict_valid;
  logic [PC_W-1:0]  predict_pc;
  logic [0:0]       predict_thread;
  logic             predict_ready;
  logic             resp_valid;
  logic             resp_hit;
  logic [TGT_W-1:0] resp_target;
  logic [1:0]       resp_type;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic [0:0]       update_thread;
  logic [TGT_W-1:0] update_target;
  logic [1:0]       update_type;
  logic             update_ready;
  logic             flush_valid;
  logic [0:0]       flush_thread;
  logic             flush_busy;
`ifdef BTB_STATS_EN
  logic [31:0]      stat_hits;
  logic [31:0]      stat_misses;
  logic [31:0]      stat_evicts;
`endif

  btb_assoc_mt #(
    .SETS(SETS), .WAYS(WAYS), .THREADS(THREADS),
    .PC_W(PC_W), .OFF_W(OFF_W), .TGT_W(TGT_W)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .predict_valid (predict_valid),
    .predict_pc    (predict_pc),
    .predict_thread(predict_thread),
    .predict_ready (predict_ready),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_target   (resp_target),
    .resp_type     (resp_type),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_thread (update_thread),
    .update_target (update_target),
    .update_type   (update_type),
    .update_ready  (update_ready),
    .flush_valid   (flush_valid),
    .flush_thread  (flush_thread),
    .flush_busy    (flush_busy)
`ifdef BTB_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_evicts   (stat_evicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic             hit;
    logic [TGT_W-1:0] tgt;
    logic [1:0]       typ;
    logic [31:0]      cyc;
  } exp_t;

  exp_t  sb_q[$];
  string sb_tag[$];
  exp_t  mon_e;
  string mon_tag;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response monitor: compares each response against the scoreboard head.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_tag = sb_tag.pop_front();
        check({mon_tag, "_latency"}, cyc, mon_e.cyc);
        check({mon_tag, "_hit"}, resp_hit, mon_e.hit);
        check({mon_tag, "_target"}, resp_target, mon_e.tgt);
        check({mon_tag, "_type"}, resp_type, mon_e.typ);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e   = sb_q.pop_front();
      mon_tag = sb_tag.pop_front();
      check({mon_tag, "_missing"}, 0, 1);
    end
  end

  function automatic logic [PC_W-1:0] mk_pc(input logic [57:0] tag, input logic [3:0] idx);
    return {tag, idx, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sets up a lookup for the current cycle (caller steps the clock).
  task automatic set_lookup(input string tag, input logic [PC_W-1:0] pc, input logic thr,
                            input logic hit, input logic [TGT_W-1:0] tgt, input logic [1:0] typ);
    exp_t e;
    predict_valid  = 1'b1;
    predict_pc     = pc;
    predict_thread = thr;
    e.hit = hit;
    e.tgt = hit ? tgt : '0;
    e.typ = hit ? typ : 2'd0;
    e.cyc = cyc + 32'd1;
    sb_q.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic set_update(input logic [PC_W-1:0] pc, input logic thr,
                            input logic [TGT_W-1:0] tgt, input logic [1:0] typ);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_thread = thr;
    update_target = tgt;
    update_type   = typ;
  endtask

  task automatic idle_inputs();
    predict_valid = 1'b0;
    update_valid  = 1'b0;
    flush_valid   = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [PC_W-1:0] pc, input logic thr,
                        input logic hit, input logic [TGT_W-1:0] tgt, input logic [1:0] typ);
    set_lookup(tag, pc, thr, hit, tgt, typ);
    step();
    idle_inputs();
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic thr,
                        input logic [TGT_W-1:0] tgt, input logic [1:0] typ);
    set_update(pc, thr, tgt, typ);
    step();
    idle_inputs();
  endtask

  // Counts cycles (including the current one) until predict_ready rises.
  task automatic count_busy(input string tag);
    int n = 0;
    while (!predict_ready && n < 100) begin
      check({tag, "_flush_busy"}, flush_busy, 1);
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, SETS);
    check({tag, "_flush_busy_end"}, flush_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    predict_pc = '0; predict_thread = '0;
    update_pc = '0; update_thread = '0; update_target = '0; update_type = '0;
    flush_thread = '0;
    idle_inputs();
    step();
    step();
    // Reset state.
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_target", resp_target, 0);
    check("rst_resp_type", resp_type, 0);
    check("rst_predict_ready", predict_ready, 0);
    check("rst_update_ready", update_ready, 0);
    check("rst_flush_busy", flush_busy, 1);
    rst = 1'b0;

    // 1: INIT sweep length, then a cold miss.
    count_busy("init");
    check("init_update_ready", update_ready, 1);
    lookup("t1_cold", 64'h1000, 1'b0, 1'b0, 0, 0);

    // 2: allocate then hit; wrong thread misses.
    update(64'h4040, 1'b1, 64'h8000, 2'd2);
    lookup("t2_hit", 64'h4040, 1'b1, 1'b1, 64'h8000, 2'd2);
    lookup("t2_thr0", 64'h4040, 1'b0, 1'b0, 0, 0);

    // 3: round-robin replacement in set 1.
    update(mk_pc(58'h10, 4'd1), 1'b0, 64'h110, 2'd1);
    update(mk_pc(58'h11, 4'd1), 1'b0, 64'h111, 2'd1);
    update(mk_pc(58'h12, 4'd1), 1'b0, 64'h112, 2'd3);
    lookup("t3_b_after_c", mk_pc(58'h11, 4'd1), 1'b0, 1'b1, 64'h111, 2'd1);
    update(mk_pc(58'h13, 4'd1), 1'b0, 64'h113, 2'd0);
    lookup("t3_a", mk_pc(58'h10, 4'd1), 1'b0, 1'b0, 0, 0);
    lookup("t3_b", mk_pc(58'h11, 4'd1), 1'b0, 1'b0, 0, 0);
    lookup("t3_c", mk_pc(58'h12, 4'd1), 1'b0, 1'b1, 64'h112, 2'd3);
    lookup("t3_d", mk_pc(58'h13, 4'd1), 1'b0, 1'b1, 64'h113, 2'd0);
    // Update hit rewrites target/type in place.
    update(mk_pc(58'h13, 4'd1), 1'b0, 64'h213, 2'd2);
    lookup("t3_d_rewrite", mk_pc(58'h13, 4'd1), 1'b0, 1'b1, 64'h213, 2'd2);
    lookup("t3_c_kept", mk_pc(58'h12, 4'd1), 1'b0, 1'b1, 64'h112, 2'd3);

    // 4: read-before-write in set 2.
    set_lookup("t4_same_cycle", mk_pc(58'h20, 4'd2), 1'b1, 1'b0, 0, 0);
    set_update(mk_pc(58'h20, 4'd2), 1'b1, 64'h220, 2'd1);
    step();
    idle_inputs();
    lookup("t4_next_cycle", mk_pc(58'h20, 4'd2), 1'b1, 1'b1, 64'h220, 2'd1);

    // 5: populate sets 0 and 5, flush thread 0 (with a concurrent update).
    update(mk_pc(58'h30, 4'd0), 1'b0, 64'hA0, 2'd1);
    update(mk_pc(58'h31, 4'd5), 1'b0, 64'hA1, 2'd1);
    check("t5_busy_before", flush_busy, 0);
    set_update(mk_pc(58'h32, 4'd5), 1'b1, 64'hB2, 2'd3);
    flush_valid  = 1'b1;
    flush_thread = 1'b0;
    step();
    idle_inputs();
    check("t5_update_ready_in_flush", update_ready, 0);
    count_busy("t5");
    lookup("t5_s0_t0", mk_pc(58'h30, 4'd0), 1'b0, 1'b0, 0, 0);
    lookup("t5_s0_t1", 64'h4040, 1'b1, 1'b1, 64'h8000, 2'd2);
    lookup("t5_s5_t0", mk_pc(58'h31, 4'd5), 1'b0, 1'b0, 0, 0);
    lookup("t5_s5_t1", mk_pc(58'h32, 4'd5), 1'b1, 1'b1, 64'hB2, 2'd3);
    lookup("t5_s1_t0", mk_pc(58'h12, 4'd1), 1'b0, 1'b0, 0, 0);
    lookup("t5_s2_t1", mk_pc(58'h20, 4'd2), 1'b1, 1'b1, 64'h220, 2'd1);

    // 6: reset at flush cycle 3.
    flush_valid  = 1'b1;
    flush_thread = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_resp_valid", resp_valid, 0);
    check("t6_predict_ready", predict_ready, 0);
    count_busy("t6");
    lookup("t6_s0_t1", 64'h4040, 1'b1, 1'b0, 0, 0);
    lookup("t6_s5_t1", mk_pc(58'h32, 4'd5), 1'b1, 1'b0, 0, 0);
    lookup("t6_s2_t1", mk_pc(58'h20, 4'd2), 1'b1, 1'b0, 0, 0);
    lookup("t6_s1_t0", mk_pc(58'h13, 4'd1), 1'b0, 1'b0, 0, 0);

    step();
    step();
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
